digit_serial_multiplier: RTL and testbench

//   Unsigned W x W multiplier built from one 2-bit x 2-bit digit multiplier.

---
 rtl/mult_pkg.sv | 14 +
 rtl/pp_mul2x2.sv | 13 +
 rtl/digit_serial_multiplier.sv | 100 ++++++++++
 tb/tb_digit_serial_multiplier.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/mult_pkg.sv
// Shared encodings and widths for the digit-serial multiplier.
// Digits are 2 bits wide; each digit product is 4 bits.
package mult_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DIGIT_W = 2;
  localparam int PP_W    = 4;

endpackage

// File: rtl/pp_mul2x2.sv
// Combinational 2-bit by 2-bit unsigned digit multiplier.
// p = x * y, at most 9, so it fits in 4 bits.
module pp_mul2x2
  import mult_pkg::*;
(
  input  logic [DIGIT_W-1:0] x,
  input  logic [DIGIT_W-1:0] y,
  output logic [PP_W-1:0]    p
);

  assign p = PP_W'(x) * PP_W'(y);

endmodule

// File: rtl/digit_serial_multiplier.sv
// Unsigned W x W multiplier that sums one 2x2 digit product per cycle.
// Fixed latency of N*N+1 cycles from accepted start to done.
module digit_serial_multiplier
  import mult_pkg::*;
#(
  parameter int W = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  output logic           busy,
  output logic           done,
  output logic [2*W-1:0] product
);

  localparam int N  = W / 2;
  localparam int NN = N * N;
  localparam int CW = (NN > 1) ? $clog2(NN) : 1;

  localparam logic [CW-1:0] NL   = CW'(N);
  localparam logic [CW-1:0] LAST = CW'(NN - 1);

  state_t           state;
  logic [W-1:0]     a_q;
  logic [W-1:0]     b_q;
  logic [2*W-1:0]   acc;
  logic [CW-1:0]    k;

  logic [CW-1:0]      di;
  logic [CW-1:0]      dj;
  logic [DIGIT_W-1:0] ad;
  logic [DIGIT_W-1:0] bd;
  logic [PP_W-1:0]    pp;
  logic [2*W-1:0]     term;
  logic [2*W-1:0]     acc_nxt;

  // k walks a-digits in the outer loop, b-digits in the inner loop
  assign di = k / NL;
  assign dj = k % NL;

  assign ad = DIGIT_W'(a_q >> (DIGIT_W * int'(di)));
  assign bd = DIGIT_W'(b_q >> (DIGIT_W * int'(dj)));

  pp_mul2x2 u_pp (
    .x (ad),
    .y (bd),
    .p (pp)
  );

  assign term    = (2*W)'(pp) << (DIGIT_W * (int'(di) + int'(dj)));
  assign acc_nxt = acc + term;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      product <= '0;
      a_q     <= '0;
      b_q     <= '0;
      acc     <= '0;
      k       <= '0;
    end else begin
      // done trails the DONE state by one edge
      done <= (state == DONE);
      unique case (state)
        IDLE: begin
          if (start) begin
            a_q   <= a;
            b_q   <= b;
            acc   <= '0;
            k     <= '0;
            state <= RUN;
            busy  <= 1'b1;
          end
        end
        RUN: begin
          acc <= acc_nxt;
          if (k == LAST) begin
            product <= acc_nxt;
            state   <= DONE;
          end else begin
            k <= k + CW'(1);
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_digit_serial_multiplier.sv
// Directed and table-driven checks for digit_serial_multiplier, W=8.
// Latency, hold, ignore-while-busy, reset abort and back-to-back ops.
module tb_digit_serial_multiplier;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [7:0]  a;
  logic [7:0]  b;
  logic        busy;
  logic        done;
  logic [15:0] product;

  int n_chk;
  int n_fail;

  digit_serial_multiplier #(.W(8)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .a       (a),
    .b       (b),
    .busy    (busy),
    .done    (done),
    .product (product)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  va;
    logic [7:0]  vb;
    logic [15:0] exp;
  } vec_t;

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // called at a negedge; returns cycles from accept edge to first done
  task automatic run_op(input logic [7:0] av, input logic [7:0] bv,
                        output int lat, output int busy_bad);
    a = av;
    b = bv;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    lat = -1;
    busy_bad = 0;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      if (done) begin
        lat = n;
        break;
      end
      if (!busy) busy_bad++;
    end
  endtask

  initial begin
    vec_t vt[5];
    int   lat;
    int   bb;
    int   ndone;
    int   gap;
    int   last_t;
    int   cyc;
    int   op;
    logic [7:0] ba[3];
    logic [7:0] bbv[3];
    logic [15:0] be[3];

    n_chk  = 0;
    n_fail = 0;
    vt[0] = '{8'd3,   8'd5,   16'd15};
    vt[1] = '{8'd255, 8'd255, 16'hFE01};
    vt[2] = '{8'd1,   8'd1,   16'd1};
    vt[3] = '{8'd128, 8'd2,   16'd256};
    vt[4] = '{8'd170, 8'd85,  16'd14450};

    rst_n = 1'b0;
    start = 1'b0;
    a = '0;
    b = '0;
    repeat (3) @(negedge clk);
    check("reset_busy", int'(busy), 0);
    check("reset_done", int'(done), 0);
    check("reset_product", int'(product), 0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int t = 0; t < 5; t++) begin
      run_op(vt[t].va, vt[t].vb, lat, bb);
      check($sformatf("tbl%0d_latency", t), lat, 17);
      check($sformatf("tbl%0d_busy", t), bb, 0);
      check($sformatf("tbl%0d_product", t), int'(product), int'(vt[t].exp));
      @(negedge clk);
      check($sformatf("tbl%0d_done_1cyc", t), int'(done), 0);
      check($sformatf("tbl%0d_hold", t), int'(product), int'(vt[t].exp));
    end

    // zero operand: full latency, prior product held until the end
    a = 8'd0;
    b = 8'd200;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    lat = -1;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      if (n == 8 || n == 15)
        check($sformatf("zero_hold_n%0d", n), int'(product), 14450);
      if (done) begin
        lat = n;
        break;
      end
    end
    check("zero_latency", lat, 17);
    check("zero_product", int'(product), 0);
    @(negedge clk);

    // start mid-RUN with new operands is ignored
    a = 8'd12;
    b = 8'd10;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    lat = -1;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      if (n == 3) begin
        a = 8'd7;
        b = 8'd9;
        start = 1'b1;
      end
      if (n == 6) start = 1'b0;
      if (done) begin
        lat = n;
        break;
      end
    end
    check("ignore_latency", lat, 17);
    check("ignore_product", int'(product), 120);
    repeat (3) @(negedge clk);
    check("ignore_no_requeue", int'(busy), 0);

    // reset asserted at RUN cycle 8
    a = 8'd9;
    b = 8'd9;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (7) @(negedge clk);
    check("abort_busy_before", int'(busy), 1);
    rst_n = 1'b0;
    #1;
    check("abort_busy", int'(busy), 0);
    check("abort_done", int'(done), 0);
    check("abort_product", int'(product), 0);
    ndone = 0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (done) ndone++;
      if (n == 2) rst_n = 1'b1;
    end
    check("abort_no_done", ndone, 0);
    run_op(8'd6, 8'd7, lat, bb);
    check("after_abort_latency", lat, 17);
    check("after_abort_product", int'(product), 42);
    @(negedge clk);

    // start held high: back-to-back ops every 18 cycles
    ba[0] = 8'd11;  bbv[0] = 8'd13; be[0] = 16'd143;
    ba[1] = 8'd200; bbv[1] = 8'd3;  be[1] = 16'd600;
    ba[2] = 8'd255; bbv[2] = 8'd1;  be[2] = 16'd255;
    op = 0;
    a = ba[0];
    b = bbv[0];
    start = 1'b1;
    last_t = 0;
    cyc = 0;
    while (op < 3 && cyc < 200) begin
      @(negedge clk);
      cyc++;
      if (done) begin
        check($sformatf("b2b%0d_product", op), int'(product), int'(be[op]));
        if (op > 0) begin
          gap = cyc - last_t;
          check($sformatf("b2b%0d_gap", op), gap, 18);
        end
        last_t = cyc;
        op++;
        if (op < 3) begin
          a = ba[op];
          b = bbv[op];
        end else begin
          start = 1'b0;
        end
      end
    end
    check("b2b_ops_done", op, 3);
    start = 1'b0;
    repeat (2) @(negedge clk);

    // strided sweep covering both corner values
    for (int ia = 0; ia < 256; ia += 17) begin
      for (int ib = 0; ib < 256; ib += 5) begin
        run_op(8'(ia), 8'(ib), lat, bb);
        check($sformatf("sweep_%0dx%0d", ia, ib), int'(product), ia * ib);
        if (lat != 17) check("sweep_latency", lat, 17);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
